score_tracker: RTL
==================

Name: score_tracker

Overview:
- Upstream feeder of the score/combo display stage.
- Accepts per-lane judgement events from the 4-lane note judge and accumulates score and combo in packed BCD, so the hex displays show decimal digits directly.
- Serialises simultaneous lane hits through a small FSM with digit-serial BCD addition.
- Also tracks max combo and flags dropped events.

Parameters:
- PTS_PERFECT, 3, hundreds digit added for grade 11 (300 points)
- PTS_GREAT, 2, hundreds digit for grade 10 (200 points)
- PTS_GOOD, 1, hundreds digit for grade 01 (100 points)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- clr  input  1  synchronous song-start clear, highest priority after rst
- hit_valid  input  4  one-cycle pulse per lane, judgement present
- hit_grade  input  8  2 bits per lane, lane i at [2i+1:2i]; 00 miss, 01 good, 10 great, 11 perfect
- score  output  32  8 packed BCD digits, digit 0 in [3:0]
- combo  output  16  4 packed BCD digits
- max_combo  output  16  4 packed BCD digits, highest combo since clear
- busy  output  1  FSM not IDLE or any lane pending
- upd  output  1  one-cycle pulse when score/combo registers update
- drop  output  1  one-cycle pulse when an event is lost

Behaviour:
- Reset (rst low, async) and clr (sync): pending, grades, accumulator, score, combo, max_combo, upd, drop all cleared to 0; FSM to IDLE. A clr mid-operation abandons the event in flight.
- Capture, per lane, every edge:
  - hit_valid[i] with pend[i]=0: set pend[i], latch grade.
  - hit_valid[i] with pend[i]=1 and lane i not being picked this edge: event discarded, drop pulses next cycle.
  - If lane i is picked on the same edge its new event arrives, the new event is captured (set wins over clear).
- FSM states: IDLE, ADD, CMB.
- IDLE: if any pend bit is set, pick the lowest-index pending lane, clear its pend bit, and latch its grade.
  - Miss: go to CMB.
  - Otherwise: load addend from the matching PTS_* value, set digit index d=2, carry=0, working acc = score, and go to ADD.
- ADD, one digit per cycle, d=2..7:
  - acc digit d = BCD(acc[d] + addend + carry).
  - carry = sum > 9; addend is zeroed after d=2.
  - After d=7, go to CMB.
  - A carry out of digit 7 sets the saturate flag.
- CMB, one cycle:
  - score <= saturate ? 0x99999999 : acc.
  - Miss: combo <= 0.
  - Non-miss: combo BCD-increments, saturating at 0x9999.
  - max_combo <= max(max_combo, new combo), compared as BCD/unsigned (equivalent for valid BCD).
  - upd pulses; go to IDLE.
- Latency, with the event captured at edge t:
  - Hit: outputs update at edge t+8 (IDLE t+1, ADD t+2..t+7, CMB t+8).
  - Miss: outputs update at edge t+2.
  - Back-to-back pending lanes add one IDLE cycle between events.
- score/combo hold stable during ADD; only CMB writes them, so display never sees partial sums.
- Digits 0-1 of score are never modified (always 0 unless saturated to 9).
- Saturation is sticky per event only; later events recompute from 0x99999999 and saturate again.
- busy = (state != IDLE) | (|pend).

Test Plan:
- Reset, then lane0 perfect pulse -> after 8 cycles score=0x00000300, combo=0x0001, max_combo=0x0001, one upd pulse.
- All 4 lanes in one cycle with grades 11,10,01,11 -> processed lane0..3 in order, final score=0x00000900, combo=0x0004, 4 upd pulses, last at t+35.
- Build combo 0x0012, then a miss -> combo=0x0000, max_combo stays 0x0012, score unchanged, upd at t+2.
- Preload score 0x00009900 via events, then a perfect -> score=0x00010200 (BCD carry ripple across digits 2-4).
- Score at 0x99999900, then perfect -> score=0x99999999. Combo at 0x9999, then a hit -> combo stays 0x9999.
- Lane2 pulse on two consecutive cycles while FSM busy on lane0 -> second lane2 event dropped, drop pulses once.
- Separately: clr asserted during ADD -> all outputs 0 next cycle, FSM IDLE, no upd.

Source files
------------

// File: rtl/score_tracker.sv
// Score/combo accumulator for the 4-lane note judge. Score, combo and max combo
// are kept in packed BCD; simultaneous lane hits are serialised one digit per cycle.
module score_tracker #(
  parameter logic [3:0] PTS_PERFECT = 4'd3,
  parameter logic [3:0] PTS_GREAT   = 4'd2,
  parameter logic [3:0] PTS_GOOD    = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [3:0]  hit_valid,
  input  logic [7:0]  hit_grade,
  output logic [31:0] score,
  output logic [15:0] combo,
  output logic [15:0] max_combo,
  output logic        busy,
  output logic        upd,
  output logic        drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CMB  = 2'd2
  } state_t;

  // Returns {carry, digit} of a single BCD digit addition.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    if (s > 5'd9) begin
      return {1'b1, s[3:0] - 4'd10};
    end else begin
      return {1'b0, s[3:0]};
    end
  endfunction

  function automatic logic [15:0] bcd_inc16_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) begin
      return v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (c && (v[4*i +: 4] == 4'd9)) begin
          r[4*i +: 4] = 4'd0;
        end else if (c) begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4];
        end
      end
      return r;
    end
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [7:0]  grade_q, grade_d;
  logic [1:0]  cur_grade_q, cur_grade_d;
  logic [3:0]  addend_q, addend_d;
  logic [2:0]  dig_q, dig_d;
  logic        carry_q, carry_d;
  logic        sat_q, sat_d;
  logic        settle_q, settle_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] score_q, score_d;
  logic [15:0] combo_q, combo_d;
  logic [15:0] max_combo_q, max_combo_d;
  logic        upd_q, upd_d;
  logic        drop_q, drop_d;

  logic [3:0]  pick_s;
  logic [1:0]  pick_lane_s;
  logic [1:0]  sel_grade_s;
  logic [4:0]  dsum_s;
  logic [15:0] combo_nx_s;

  // A lane can only be picked from IDLE, and not in the dwell cycle right after CMB.
  always_comb begin
    pick_s      = 4'b0000;
    pick_lane_s = 2'd0;
    if ((state_q == IDLE) && !settle_q) begin
      casez (pend_q)
        4'b???1: begin pick_s = 4'b0001; pick_lane_s = 2'd0; end
        4'b??10: begin pick_s = 4'b0010; pick_lane_s = 2'd1; end
        4'b?100: begin pick_s = 4'b0100; pick_lane_s = 2'd2; end
        4'b1000: begin pick_s = 4'b1000; pick_lane_s = 2'd3; end
        default: begin pick_s = 4'b0000; pick_lane_s = 2'd0; end
      endcase
    end else begin
      pick_s      = 4'b0000;
      pick_lane_s = 2'd0;
    end
    sel_grade_s = grade_q[{pick_lane_s, 1'b0} +: 2];
  end

  // Per-lane capture: a new event beats the clear of a lane picked on the same edge.
  always_comb begin
    pend_d  = pend_q;
    grade_d = grade_q;
    drop_d  = 1'b0;
    if (clr) begin
      pend_d  = 4'b0000;
      grade_d = 8'h00;
      drop_d  = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hit_valid[i] && (!pend_q[i] || pick_s[i])) begin
          pend_d[i]         = 1'b1;
          grade_d[2*i +: 2] = hit_grade[2*i +: 2];
        end else if (pick_s[i]) begin
          pend_d[i] = 1'b0;
        end else if (hit_valid[i]) begin
          drop_d = 1'b1;
        end else begin
          pend_d[i] = pend_q[i];
        end
      end
    end
  end

  // Event FSM: digit-serial BCD add into acc, then commit score/combo in CMB.
  always_comb begin
    state_d     = state_q;
    cur_grade_d = cur_grade_q;
    addend_d    = addend_q;
    dig_d       = dig_q;
    carry_d     = carry_q;
    sat_d       = sat_q;
    settle_d    = settle_q;
    acc_d       = acc_q;
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    upd_d       = 1'b0;
    dsum_s      = 5'd0;
    combo_nx_s  = 16'h0000;
    if (clr) begin
      state_d     = IDLE;
      cur_grade_d = 2'b00;
      addend_d    = 4'd0;
      dig_d       = 3'd0;
      carry_d     = 1'b0;
      sat_d       = 1'b0;
      settle_d    = 1'b0;
      acc_d       = 32'h0000_0000;
      score_d     = 32'h0000_0000;
      combo_d     = 16'h0000;
      max_combo_d = 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          settle_d = 1'b0;
          if (|pick_s) begin
            cur_grade_d = sel_grade_s;
            acc_d       = score_q;
            sat_d       = 1'b0;
            carry_d     = 1'b0;
            dig_d       = 3'd2;
            case (sel_grade_s)
              2'b11:   addend_d = PTS_PERFECT;
              2'b10:   addend_d = PTS_GREAT;
              2'b01:   addend_d = PTS_GOOD;
              default: addend_d = 4'd0;
            endcase
            if (sel_grade_s == 2'b00) begin
              state_d = CMB;
            end else begin
              state_d = ADD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        ADD: begin
          dsum_s = bcd_digit_add(acc_q[{dig_q, 2'b00} +: 4], addend_q, carry_q);
          acc_d[{dig_q, 2'b00} +: 4] = dsum_s[3:0];
          carry_d  = dsum_s[4];
          addend_d = 4'd0;
          if (dig_q == 3'd7) begin
            sat_d   = dsum_s[4];
            state_d = CMB;
          end else begin
            dig_d = dig_q + 3'd1;
          end
        end
        CMB: begin
          score_d = sat_q ? 32'h9999_9999 : acc_q;
          if (cur_grade_q == 2'b00) begin
            combo_nx_s = 16'h0000;
          end else begin
            combo_nx_s = bcd_inc16_sat(combo_q);
          end
          combo_d     = combo_nx_s;
          max_combo_d = (combo_nx_s > max_combo_q) ? combo_nx_s : max_combo_q;
          upd_d       = 1'b1;
          settle_d    = 1'b1;
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_q      <= 4'b0000;
      grade_q     <= 8'h00;
      cur_grade_q <= 2'b00;
      addend_q    <= 4'd0;
      dig_q       <= 3'd0;
      carry_q     <= 1'b0;
      sat_q       <= 1'b0;
      settle_q    <= 1'b0;
      acc_q       <= 32'h0000_0000;
      score_q     <= 32'h0000_0000;
      combo_q     <= 16'h0000;
      max_combo_q <= 16'h0000;
      upd_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      grade_q     <= grade_d;
      cur_grade_q <= cur_grade_d;
      addend_q    <= addend_d;
      dig_q       <= dig_d;
      carry_q     <= carry_d;
      sat_q       <= sat_d;
      settle_q    <= settle_d;
      acc_q       <= acc_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      upd_q       <= upd_d;
      drop_q      <= drop_d;
    end
  end

  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_combo_q;
  assign upd       = upd_q;
  assign drop      = drop_q;
  assign busy      = (state_q != IDLE) | (|pend_q);

endmodule
